// File: rtl/hir_mem_pkg.sv
// Shared definitions for the HIR scheduled memory primitives.
package hir_mem_pkg;

    localparam int HIR_MAX_RD_LATENCY = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_clr_state_t;

    // Address width that never collapses to zero bits for tiny memories.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_r1_w1_if.sv
// HIR memory-port bundle: p0 read port, p1 write port, plus responder status.
interface mem_r1_w1_if #(
    parameter int ELEMENT_WIDTH = 32,
    parameter int ADDR_WIDTH    = 4
);
    logic                     p0_rd_en;
    logic [ADDR_WIDTH-1:0]    p0_addr;
    logic [ELEMENT_WIDTH-1:0] p0_rd_data;
    logic                     p0_rd_valid;
    logic                     p1_wr_en;
    logic [ADDR_WIDTH-1:0]    p1_addr;
    logic [ELEMENT_WIDTH-1:0] p1_wr_data;
    logic                     busy;
    logic                     err_oob;

    modport master (
        output p0_rd_en, p0_addr, p1_wr_en, p1_addr, p1_wr_data,
        input  p0_rd_data, p0_rd_valid, busy, err_oob
    );

    modport slave (
        input  p0_rd_en, p0_addr, p1_wr_en, p1_addr, p1_wr_data,
        output p0_rd_data, p0_rd_valid, busy, err_oob
    );
endinterface

// File: rtl/hir_delay_line.sv
// Fixed-length register delay line with async reset to zero; DEPTH=0 is a wire.
module hir_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    if (DEPTH == 0) begin : g_wire
        assign dout = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            end else begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign dout = stage[DEPTH-1];
    end
endmodule

// File: rtl/mem_r1_w1.sv
// mem_r1_w1: HIR memory-port responder with one read port (p0) and one write port (p1).
// Build option MEM_R1_W1_WR_FORWARD_EN: same-cycle write-first forwarding to the read port.
import hir_mem_pkg::*;

module mem_r1_w1 #(
    parameter int ELEMENT_WIDTH = 32,
    parameter int DEPTH         = 16,
    parameter int ADDR_WIDTH    = clog2_min1(DEPTH),
    parameter int RD_LATENCY    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       t,
    mem_r1_w1_if.slave bus
);
    if (RD_LATENCY < 1 || RD_LATENCY > HIR_MAX_RD_LATENCY) begin : g_bad_latency
        $error("mem_r1_w1: RD_LATENCY must be within 1..%0d", HIR_MAX_RD_LATENCY);
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("mem_r1_w1: DEPTH must be at least 2");
    end

    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(DEPTH - 1);

    // t only exists to keep the HIR call signature uniform.
    logic unused_t;
    assign unused_t = t;

    mem_clr_state_t           state, state_nxt;
    logic [ADDR_WIDTH-1:0]    clr_cnt, clr_cnt_nxt;
    logic                     busy;
    logic [ELEMENT_WIDTH-1:0] mem [DEPTH];

    logic                     rd_in_range, wr_in_range;
    logic                     rd_accept, wr_accept;
    logic [ELEMENT_WIDTH-1:0] rd_sample;
    logic                     vld_p0;
    logic [ELEMENT_WIDTH-1:0] rd_data_p0;
    logic [ELEMENT_WIDTH:0]   rd_tail;
    logic                     err_oob;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        busy        = 1'b0;
        case (state)
            CLEAR: begin
                busy = 1'b1;
                if (clr_cnt == CLR_LAST) state_nxt = READY;
                else clr_cnt_nxt = clr_cnt + 1'b1;
            end
            READY: begin
                busy = 1'b0;
            end
        endcase
    end

    assign rd_in_range = {1'b0, bus.p0_addr} < DEPTH_W;
    assign wr_in_range = {1'b0, bus.p1_addr} < DEPTH_W;
    assign rd_accept   = !busy && bus.p0_rd_en;
    assign wr_accept   = !busy && bus.p1_wr_en && wr_in_range;

    // The clear sequencer owns the write port while busy.
    always_ff @(posedge clk) begin
        if (busy) mem[clr_cnt] <= '0;
        else if (wr_accept) mem[bus.p1_addr] <= bus.p1_wr_data;
    end

    always_comb begin
        rd_sample = '0;
        if (rd_in_range) rd_sample = mem[bus.p0_addr];
`ifdef MEM_R1_W1_WR_FORWARD_EN
        if (rd_in_range && wr_accept && (bus.p1_addr == bus.p0_addr)) rd_sample = bus.p1_wr_data;
`endif
    end

    // Stage p0: array sample. Data is only loaded on an accepted read, so every
    // later stage carries the last response while its valid bit is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0     <= 1'b0;
            rd_data_p0 <= '0;
        end else begin
            vld_p0 <= rd_accept;
            if (rd_accept) rd_data_p0 <= rd_sample;
        end
    end

    hir_delay_line #(
        .WIDTH (ELEMENT_WIDTH + 1),
        .DEPTH (RD_LATENCY - 1)
    ) u_rd_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({vld_p0, rd_data_p0}),
        .dout (rd_tail)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_oob <= 1'b0;
        else if (!busy && ((bus.p0_rd_en && !rd_in_range) || (bus.p1_wr_en && !wr_in_range)))
            err_oob <= 1'b1;
    end

    assign bus.p0_rd_valid = rd_tail[ELEMENT_WIDTH];
    assign bus.p0_rd_data  = rd_tail[ELEMENT_WIDTH-1:0];
    assign bus.busy        = busy;
    assign bus.err_oob     = err_oob;
endmodule

// File: doc/mem_r1_w1.md
Name: mem_r1_w1

Overview:
- Responder side of the HIR memory-port protocol.
- Serves a read port (p0: rd_en/addr → rd_data) and a write port (p1: wr_en/addr/wr_data) issued by scheduled initiators such as stencil or weighted-sum kernels.
- Backed by an internal array with a fixed, parameterised read latency, so the initiator's static schedule holds.
- Self-clears its contents after reset before accepting traffic.

Parameters:
- ELEMENT_WIDTH, 32, data bits per element
- DEPTH, 16, number of elements (≥2)
- ADDR_WIDTH, $clog2(DEPTH), address bits
- RD_LATENCY, 1, cycles from p0_rd_en to p0_rd_data (legal 1..4; outside range is an elaboration error)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- t  in  1  schedule start pulse; unused internally, kept for HIR call-convention uniformity
- p0_rd_en  in  1  read request
- p0_addr  in  ADDR_WIDTH  read address
- p0_rd_data  out  ELEMENT_WIDTH  read data, RD_LATENCY after request
- p0_rd_valid  out  1  high in the cycle p0_rd_data carries a response
- p1_wr_en  in  1  write request
- p1_addr  in  ADDR_WIDTH  write address
- p1_wr_data  in  ELEMENT_WIDTH  write data
- busy  out  1  high while the clear sequencer runs; requests are ignored
- err_oob  out  1  sticky: an accepted request used an address ≥ DEPTH

Behaviour:
- Reset is asynchronous, active-high.
  - Outputs while rst is high: p0_rd_data=0, p0_rd_valid=0, err_oob=0, busy=1.
  - The read pipeline is flushed.
  - Array contents are not reset asynchronously.
- FSM states: CLEAR, READY.
  - Reset enters CLEAR with clear counter = 0.
  - CLEAR: each cycle writes 0 to array[counter] and increments the counter. After the write at DEPTH-1, move to READY on the next edge, so busy is high for exactly DEPTH cycles after rst falls.
  - READY: busy=0. Stays in READY until the next reset.
- Requests while busy are dropped silently. No response, no error, p0_rd_valid stays 0.
- Write (READY, p1_wr_en=1, p1_addr<DEPTH): array[p1_addr] ← p1_wr_data at that edge.
- Read (READY, p0_rd_en=1, p0_addr<DEPTH):
  - array[p0_addr] is sampled at the request edge.
  - It appears on p0_rd_data with p0_rd_valid=1 exactly RD_LATENCY cycles after the request cycle. RD_LATENCY=1 means the next cycle.
- Throughput: one read and one write per cycle, fully pipelined. Back-to-back reads give back-to-back responses in order.
- p0_rd_data holds its last response value when p0_rd_valid=0. It never returns to 0 except on reset.
- Same address, same cycle read and write: read-first (returns the old value) unless WR_FORWARD_EN.
- Out-of-range address (ADDR_WIDTH allows addr ≥ DEPTH when DEPTH is not a power of 2):
  - Write: dropped, err_oob set.
  - Read: produces a response of 0 with p0_rd_valid=1 at the normal latency; err_oob set.
- err_oob stays set until reset.
- Reset mid-operation discards all in-flight reads (no valid pulses) and restarts CLEAR.

Optional Feature:
- Macro: MEM_R1_W1_WR_FORWARD_EN.
- When defined: a same-cycle read and write to the same valid address returns p1_wr_data (write-first forwarding). Forwarding applies only to the same cycle; later reads see the array, which already holds the new value.
- When undefined: read-first, returns the prior contents.

Decomposition:
- Shared package hir_mem_pkg:
  - Constant HIR_MAX_RD_LATENCY=4.
  - Enum typedef mem_clr_state_t {CLEAR, READY}.
  - Function clog2_min1 (gives ADDR_WIDTH ≥1 for DEPTH=2).
- Natural sub-module: hir_delay_line (WIDTH, DEPTH parameters, async reset to 0). It carries {valid, data} through the RD_LATENCY-1 stages after the array sample. Reusable by other scheduled HIR primitives.

Test Plan:
- Reset, then release → busy high for exactly 16 cycles (DEPTH=16). Reading addr 5 afterwards returns 0 with valid one cycle later.
- Write 0xDEADBEEF to addr 3, read addr 3 next cycle → p0_rd_data=0xDEADBEEF, p0_rd_valid=1 one cycle after the read.
- RD_LATENCY=3: reads of addrs 0,1,2 on consecutive cycles (preloaded 10,11,12) → valid pulses 3 cycles later on consecutive cycles with data 10,11,12. Data holds 12 afterwards.
- Same-cycle write 0x55 and read at addr 7, old value 0x11 → response 0x11 without the macro, 0x55 with MEM_R1_W1_WR_FORWARD_EN. A re-read returns 0x55 in both builds.
- DEPTH=10, read addr 12 → response 0 with valid, err_oob=1 and sticky. Write addr 12 leaves all entries unchanged.
- Assert rst while 2 reads are in flight (RD_LATENCY=3) → no valid pulses, outputs 0, busy=1, and CLEAR reruns for DEPTH cycles. Reads issued during busy give no response.
